// File: rtl/qgen_pkg.sv
// Shared types and helpers for the quadrature generator: FSM states,
// 2-bit {a,b} phase codes and the Gray-code step functions.
package qgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } qgen_state_e;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  // Forward rotation: 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] next_phase_fwd(input logic [1:0] ph);
    case (ph)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

  // Backward rotation: 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] next_phase_bwd(input logic [1:0] ph);
    case (ph)
      PH_00:   return PH_10;
      PH_10:   return PH_11;
      PH_11:   return PH_01;
      default: return PH_00;
    endcase
  endfunction

endpackage

// File: rtl/quad_encoder_gen_if.sv
// Command channel of the quadrature generator: valid/ready handshake
// carrying a signed step count and a per-edge period in clocks.
interface quad_encoder_gen_if #(
  parameter int CNT_W = 32,
  parameter int DIV_W = 16
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic signed [CNT_W-1:0] cmd_steps;
  logic        [DIV_W-1:0] cmd_period;

  modport master (output cmd_valid, cmd_steps, cmd_period, input cmd_ready);
  modport slave  (input cmd_valid, cmd_steps, cmd_period, output cmd_ready);
endinterface

// File: rtl/qgen_divider.sv
// Edge-rate divider: counts enabled cycles and ticks on the cycle the
// count reaches period-1, then wraps to 0. period must be non-zero.
module qgen_divider #(
  parameter int DIV_W = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q;
  logic             wrap;

  assign wrap = (cnt_q == period - DIV_W'(1));
  assign tick = enable && wrap;

  // Count while enabled; freeze otherwise so a pause shifts all later edges.
  always_ff @(posedge aclk) begin
    if (areset || clear)
      cnt_q <= '0;
    else if (enable)
      cnt_q <= wrap ? '0 : cnt_q + DIV_W'(1);
  end
endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator. Accepts {steps, period} commands and emits
// a Gray-coded enc_a/enc_b stream, one edge per period clocks, while
// tracking the emitted position. Optional build macro QGEN_ERR_INJECT_EN
// adds inj_err, which turns a tick into an illegal double-step.
module quad_encoder_gen
  import qgen_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int DIV_W = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  quad_encoder_gen_if.slave       cmd,
  input  logic                    enable,
  input  logic                    abort,
`ifdef QGEN_ERR_INJECT_EN
  input  logic                    inj_err,
`endif
  output logic                    enc_a,
  output logic                    enc_b,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic signed [CNT_W-1:0] position,
  output logic                    dir
);
  qgen_state_e      state_q, state_d;
  logic [CNT_W-1:0] rem_q;
  logic [DIV_W-1:0] period_q;
  logic             fwd_q;
  logic             aborted_q;
  logic [1:0]       phase_q;
  logic [CNT_W-1:0] steps_u;
  logic [CNT_W-1:0] mag;
  logic             accept;
  logic             tick;
  logic             inj;

  // Magnitude as unsigned so the most-negative count maps to 2^(CNT_W-1).
  assign steps_u = cmd.cmd_steps;
  assign mag     = steps_u[CNT_W-1] ? (~steps_u + CNT_W'(1)) : steps_u;
  assign accept  = (state_q == IDLE) && cmd.cmd_valid;

`ifdef QGEN_ERR_INJECT_EN
  assign inj = inj_err;
`else
  assign inj = 1'b0;
`endif

  qgen_divider #(.DIV_W(DIV_W)) u_div (
    .aclk   (aclk),
    .areset (areset),
    .clear  (accept),
    .enable ((state_q == RUN) && enable),
    .period (period_q),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: a zero-step command goes straight to DONE; the last tick
  // or an abort ends RUN (a coincident tick is still performed).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd.cmd_valid) state_d = (mag == '0) ? DONE : RUN;
      RUN:     if (abort || (tick && rem_q == CNT_W'(1))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch and per-tick phase/position update. Phase is never
  // cleared between commands so the emitted stream stays continuous.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rem_q     <= '0;
      period_q  <= DIV_W'(1);
      fwd_q     <= 1'b1;
      aborted_q <= 1'b0;
      phase_q   <= PH_00;
      position  <= '0;
      dir       <= 1'b1;
    end else begin
      aborted_q <= (state_q == RUN) && abort;
      if (accept) begin
        rem_q    <= mag;
        fwd_q    <= ~steps_u[CNT_W-1];
        period_q <= (cmd.cmd_period == '0) ? DIV_W'(1) : cmd.cmd_period;
      end else if (tick) begin
        rem_q <= rem_q - CNT_W'(1);
        if (inj) begin
          phase_q <= phase_q ^ 2'b11;
        end else begin
          phase_q  <= fwd_q ? next_phase_fwd(phase_q) : next_phase_bwd(phase_q);
          position <= fwd_q ? position + CNT_W'(1) : position - CNT_W'(1);
          dir      <= fwd_q;
        end
      end
    end
  end

  assign {enc_a, enc_b} = phase_q;
  assign cmd.cmd_ready  = (state_q == IDLE);
  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign aborted        = (state_q == DONE) && aborted_q;

endmodule
